div4_seq: RTL and testbench

Sequential unsigned 8-by-4 divider: the inverse of the calculator's 4x4 combinational multiplier. Accepts an 8-bit dividend and a 4-bit divisor on a start pulse, runs restoring division one quotient bit per clock, and returns an 8-bit quotient and a 4-bit remainder with a one-cycle done pulse. It sits beside the multiplier in the calculator datapath and closes the loop: `(A*B)/B == A` for nonzero B.

---
 rtl/div4_pkg.sv | 18 +
 rtl/div4_step.sv | 29 ++
 rtl/div4_seq.sv | 114 +++++++++++
 tb/tb_div4_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div4_pkg.sv
// Shared types and constants for the sequential 8-by-4 restoring divider.
// Used by div4_step and div4_seq; DIV4_DBZ_EN selects the divide-by-zero short-circuit.
package div4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int REM_W      = 5;

  localparam logic [2:0]            ITER_LAST    = 3'd7;
  localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/div4_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// and keep the difference only when it does not go negative.
module div4_step
  import div4_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 quotient_bit
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] divisor_ext;

  // rem_in[4] is always clear between steps; if it were set the true shifted
  // value would exceed any divisor, so it still forces a subtract.
  always_comb begin
    shifted      = {rem_in[DIVISOR_W-1:0], dividend_bit};
    divisor_ext  = {1'b0, divisor};
    rem_out      = shifted;
    quotient_bit = 1'b0;
    if (rem_in[REM_W-1] || (shifted >= divisor_ext)) begin
      rem_out      = shifted - divisor_ext;
      quotient_bit = 1'b1;
    end
  end

endmodule

// File: rtl/div4_seq.sv
// Sequential unsigned 8-by-4 divider, one quotient bit per clock, MSB first.
// Define DIV4_DBZ_EN to add the div_by_zero port and the one-cycle zero-divisor path.
module div4_seq
  import div4_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done
`ifdef DIV4_DBZ_EN
  ,
  output logic                  div_by_zero
`endif
);

  state_t state, state_next;

  logic [2:0]            cnt;
  logic [DIVIDEND_W-1:0] dividend_r;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic [REM_W-1:0]      rem_r;
  logic [DIVIDEND_W-2:0] q_sh;

  logic [REM_W-1:0]      rem_next;
  logic                  q_bit;
  logic                  accept;
  logic                  last_step;
  logic                  zero_shortcut;

  div4_step u_step (
    .rem_in       (rem_r),
    .dividend_bit (dividend_r[cnt]),
    .divisor      (divisor_r),
    .rem_out      (rem_next),
    .quotient_bit (q_bit)
  );

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == 3'd0);

`ifdef DIV4_DBZ_EN
  assign zero_shortcut = (divisor == '0);
`else
  assign zero_shortcut = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = zero_shortcut ? DONE : RUN;
      RUN:  if (cnt == 3'd0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and iteration; the visible results only change on the last step
  // (or on an accepted zero-divisor start when the short-circuit is built in).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      rem_r      <= '0;
      q_sh       <= '0;
      quotient   <= '0;
      remainder  <= '0;
    end else if (accept) begin
      cnt        <= ITER_LAST;
      dividend_r <= dividend;
      divisor_r  <= divisor;
      rem_r      <= '0;
      q_sh       <= '0;
      if (zero_shortcut) begin
        quotient  <= DBZ_QUOTIENT;
        remainder <= dividend[DIVISOR_W-1:0];
      end
    end else if (state == RUN) begin
      cnt   <= cnt - 3'd1;
      rem_r <= rem_next;
      q_sh  <= {q_sh[DIVIDEND_W-3:0], q_bit};
      if (last_step) begin
        quotient  <= {q_sh, q_bit};
        remainder <= rem_next[DIVISOR_W-1:0];
      end
    end
  end

`ifdef DIV4_DBZ_EN
  logic dbz_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        dbz_r <= 1'b0;
    else if (accept)                dbz_r <= zero_shortcut;
    else if (last_step)             dbz_r <= 1'b0;
  end

  assign div_by_zero = dbz_r;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div4_seq.sv
// Scoreboard-based bench for div4_seq: expected results are queued at start and popped on done.
// Works with and without DIV4_DBZ_EN.
module tb_div4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
`ifdef DIV4_DBZ_EN
  logic       div_by_zero;
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 9;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];

  div4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done)
`ifdef DIV4_DBZ_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    logic [7:0] rem8;
    e.dbz = 1'b0;
    if (b == 4'd0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
`ifdef DIV4_DBZ_EN
      e.dbz = 1'b1;
`endif
    end else begin
      e.q  = a / {4'd0, b};
      rem8 = a % {4'd0, b};
      e.r  = rem8[3:0];
    end
    return e;
  endfunction

  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the start edge; returns at the done cycle.
  task automatic wait_done(output int cycles, output int busy_cycles, output bit overlap,
                           output bit held_changed, output bit timeout);
    logic [7:0] q0;
    logic [3:0] r0;
    q0 = quotient;
    r0 = remainder;
    cycles = 1;
    busy_cycles = 0;
    overlap = 1'b0;
    held_changed = 1'b0;
    while (!done && cycles < 30) begin
      if (busy) busy_cycles++;
      if (quotient !== q0 || remainder !== r0) held_changed = 1'b1;
      @(negedge clk);
      cycles++;
    end
    timeout = !done;
    overlap = busy && done;
  endtask

  function automatic exp_t pop_expected();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({quotient, remainder, busy, done} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got q=%0d r=%0d busy=%0b done=%0b, expected all 0",
               quotient, remainder, busy, done);
    end
`ifdef DIV4_DBZ_EN
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dbz: got %0b, expected 0", div_by_zero);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic(input logic [7:0] a, input logic [3:0] b, input string tag);
    int cyc, bcyc;
    bit ov, held, to;
    exp_t e;
    launch(a, b);
    wait_done(cyc, bcyc, ov, held, to);
    e = pop_expected();
    checks++;
    if (to || cyc != 9) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d cycles (timeout=%0b), expected 9", tag, cyc, to);
    end
    checks++;
    if (bcyc != 8) begin
      errors++;
      $display("[TB] FAIL %s_busy_cycles: got %0d, expected 8", tag, bcyc);
    end
    checks++;
    if (ov || held) begin
      errors++;
      $display("[TB] FAIL %s_busy_done_or_hold: overlap=%0b results_changed=%0b, expected 0 0", tag, ov, held);
    end
    checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("[TB] FAIL %s_result: got q=%0d r=%0d, expected q=%0d r=%0d", tag, quotient, remainder, e.q, e.r);
    end
`ifdef DIV4_DBZ_EN
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_dbz: got %0b, expected 0", tag, div_by_zero);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done_pulse: got done=%0b busy=%0b after pulse, expected 0 0", tag, done, busy);
    end
  endtask

  task automatic test_div_zero();
    int cyc, bcyc;
    bit ov, held, to;
    exp_t e;
    launch(8'h5A, 4'd0);
    wait_done(cyc, bcyc, ov, held, to);
    e = pop_expected();
    checks++;
    if (to || cyc != DBZ_LAT) begin
      errors++;
      $display("[TB] FAIL dbz_latency: got %0d cycles (timeout=%0b), expected %0d", cyc, to, DBZ_LAT);
    end
    checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("[TB] FAIL dbz_result: got q=%h r=%h, expected q=%h r=%h", quotient, remainder, e.q, e.r);
    end
`ifdef DIV4_DBZ_EN
    checks++;
    if (div_by_zero !== e.dbz) begin
      errors++;
      $display("[TB] FAIL dbz_flag: got %0b, expected %0b", div_by_zero, e.dbz);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_held_start();
    int cyc, bcyc;
    bit ov, held, to;
    exp_t e;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    sb.push_back(model(8'd100, 4'd3));
    @(negedge clk);
    wait_done(cyc, bcyc, ov, held, to);
    e = pop_expected();
    checks++;
    if (to || cyc != 9 || bcyc != 8 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("[TB] FAIL held_first: got cyc=%0d busy=%0d q=%0d r=%0d, expected cyc=9 busy=8 q=%0d r=%0d",
               cyc, bcyc, quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_idle_gap: got busy=%0b done=%0b, expected 0 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_reaccept: got busy=%0b, expected 1", busy);
    end
    start = 1'b0;
    sb.push_back(model(8'd100, 4'd3));
    wait_done(cyc, bcyc, ov, held, to);
    e = pop_expected();
    checks++;
    if (to || cyc != 9 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("[TB] FAIL held_second: got cyc=%0d q=%0d r=%0d, expected cyc=9 q=%0d r=%0d",
               cyc, quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    launch(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({quotient, remainder, busy, done} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got q=%0d r=%0d busy=%0b done=%0b, expected all 0",
               quotient, remainder, busy, done);
    end
`ifdef DIV4_DBZ_EN
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset_dbz: got %0b, expected 0", div_by_zero);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL midrun_no_done: got activity after reset, expected none");
    end
    test_basic(8'd50, 4'd6, "after_reset");
  endtask

  task automatic test_sweep();
    int cyc, bcyc, recon;
    bit ov, held, to;
    exp_t e;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        launch(8'(a), 4'(b));
        wait_done(cyc, bcyc, ov, held, to);
        e = pop_expected();
        recon = int'(quotient) * b + int'(remainder);
        checks++;
        if (to || quotient !== e.q || remainder !== e.r || recon != a || int'(remainder) >= b) begin
          errors++;
          $display("[TB] FAIL sweep_%0d_%0d: got q=%0d r=%0d (timeout=%0b), expected q=%0d r=%0d",
                   a, b, quotient, remainder, to, e.q, e.r);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'd200, 4'd7, "d200_7");
    test_basic(8'd255, 4'd15, "d255_15");
    test_basic(8'd9, 4'd10, "d9_10");
    test_div_zero();
    test_basic(8'd77, 4'd5, "after_dbz");
    test_held_start();
    test_reset_midrun();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
